// File: rtl/shiftreg_ram_ctrl.sv
// Fixed-depth delay line built on an external synchronous RAM.
// Ports: CLK/reset_n, flush, in_* and out_* valid/ready streams, ram_* port, primed/count status.
module shiftreg_ram_ctrl #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 8,
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int CW = $clog2(SIZE + 1)
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             ram_we,
  output logic [AW-1:0]    ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_re,
  output logic [AW-1:0]    ram_raddr,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic             primed,
  output logic [CW-1:0]    count
);

  typedef enum logic {FILL, RUN} state_e;

  localparam logic [AW-1:0] PTR_LAST = AW'(SIZE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovld_q, ovld_d;
  logic            accept;
  logic            run_acc;

  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      in_ready = (state_q == FILL) | !ovld_q | out_ready;
    end
  end

  // reset_n gates the RAM strobes so nothing is written while held in reset
  assign accept  = in_valid & in_ready & reset_n;
  assign run_acc = accept & (state_q == RUN);

  // read-first RAM: the slot about to be overwritten holds the sample SIZE accepts old
  assign ram_we    = accept;
  assign ram_waddr = ptr_q;
  assign ram_wdata = in_data;
  assign ram_re    = run_acc;
  assign ram_raddr = ptr_q;

  // RAM holds rdata while ram_re=0, so the output stage needs no data register
  assign out_data  = ram_rdata;
  assign out_valid = ovld_q;
  assign primed    = (state_q == RUN);
  assign count     = count_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    ovld_d  = ovld_q;
    if (flush) begin
      state_d = FILL;
      ptr_d   = '0;
      count_d = '0;
      ovld_d  = 1'b0;
    end else begin
      if (accept) begin
        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        if (state_q == FILL) begin
          count_d = count_q + 1'b1;
          if (count_q == CNT_LAST) begin
            state_d = RUN;
          end
        end
      end
      if (run_acc) begin
        ovld_d = 1'b1;
      end else if (ovld_q && out_ready) begin
        ovld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      ptr_q   <= '0;
      count_q <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovld_q  <= ovld_d;
    end
  end

endmodule

// File: tb/tb_shiftreg_ram_ctrl.sv
// Bench for shiftreg_ram_ctrl: SIZE=4 and SIZE=1 builds share one stimulus stream.
// Each build is checked against a queue-style model of accepted/consumed samples.
module tb_shiftreg_ram_ctrl;

  logic       CLK = 1'b0;
  logic       reset_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       rdy   [2];
  logic       ovld  [2];
  logic       we    [2];
  logic       re    [2];
  logic       prim  [2];
  logic [7:0] odat  [2];
  logic [7:0] wdat  [2];
  logic [7:0] rdat  [2];
  logic [1:0] wa0, ra0;
  logic [0:0] wa1, ra1;
  logic [2:0] cnt0;
  logic [0:0] cnt1;

  logic [7:0] mem0 [0:3];
  logic [7:0] mem1 [0:0];

  int checks = 0;
  int failures = 0;

  int         nacc [2];
  int         ncons[2];
  logic [7:0] hist [2][0:4095];

  always #5 CLK = ~CLK;

  shiftreg_ram_ctrl #(.SIZE(4), .WIDTH(8)) u4 (
    .CLK(CLK), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .out_valid(ovld[0]), .out_ready(out_ready), .out_data(odat[0]),
    .ram_we(we[0]), .ram_waddr(wa0), .ram_wdata(wdat[0]),
    .ram_re(re[0]), .ram_raddr(ra0), .ram_rdata(rdat[0]),
    .primed(prim[0]), .count(cnt0)
  );

  shiftreg_ram_ctrl #(.SIZE(1), .WIDTH(8)) u1 (
    .CLK(CLK), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .out_valid(ovld[1]), .out_ready(out_ready), .out_data(odat[1]),
    .ram_we(we[1]), .ram_waddr(wa1), .ram_wdata(wdat[1]),
    .ram_re(re[1]), .ram_raddr(ra1), .ram_rdata(rdat[1]),
    .primed(prim[1]), .count(cnt1)
  );

  // read-first synchronous RAMs that hold rdata while re=0
  always @(posedge CLK) begin
    if (re[0]) rdat[0] <= mem0[ra0];
    if (we[0]) mem0[wa0] <= wdat[0];
    if (re[1]) rdat[1] <= mem1[ra1];
    if (we[1]) mem1[wa1] <= wdat[1];
  end

  task automatic chk(input string tag, input int i,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[sz%0d] observed=%0h expected=%0h",
             tag, (i == 0) ? 4 : 1, obs, exp);
    end
  endtask

  function automatic logic [31:0] waddr_of(input int i);
    return (i == 0) ? {30'b0, wa0} : {31'b0, wa1};
  endfunction

  function automatic logic [31:0] cnt_of(input int i);
    return (i == 0) ? {29'b0, cnt0} : {31'b0, cnt1};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      nacc[i]  = 0;
      ncons[i] = 0;
    end
  endtask

  // one clock: drive at negedge, check, take the posedge, update model
  task automatic cyc(input logic v, input logic [7:0] d,
                     input logic orr, input logic fl);
    bit acc [2];
    bit con [2];
    int sz, avail;
    bit erdy;
    in_valid  = v;
    in_data   = d;
    out_ready = orr;
    flush     = fl;
    #1;
    for (int i = 0; i < 2; i++) begin
      sz    = (i == 0) ? 4 : 1;
      avail = ((nacc[i] > sz) ? nacc[i] - sz : 0) - ncons[i];
      erdy  = !fl && ((nacc[i] < sz) || avail == 0 || orr);
      acc[i] = v && erdy;
      con[i] = (avail > 0) && orr;
      chk("in_ready", i, 32'(rdy[i]), 32'(erdy));
      chk("ram_we", i, 32'(we[i]), 32'(acc[i]));
      chk("ram_re", i, 32'(re[i]), 32'(acc[i] && nacc[i] >= sz));
      if (acc[i]) begin
        chk("ram_waddr", i, waddr_of(i), 32'(nacc[i] % sz));
        chk("ram_wdata", i, 32'(wdat[i]), 32'(d));
      end
      chk("out_valid", i, 32'(ovld[i]), 32'(avail > 0));
      if (avail > 0)
        chk("out_data", i, 32'(odat[i]), 32'(hist[i][ncons[i]]));
      chk("count", i, cnt_of(i), 32'((nacc[i] < sz) ? nacc[i] : sz));
      chk("primed", i, 32'(prim[i]), 32'(nacc[i] >= sz));
    end
    @(posedge CLK);
    for (int i = 0; i < 2; i++) begin
      if (fl) begin
        nacc[i]  = 0;
        ncons[i] = 0;
      end else begin
        if (acc[i]) begin
          hist[i][nacc[i]] = d;
          nacc[i]++;
        end
        if (con[i]) ncons[i]++;
      end
    end
    @(negedge CLK);
  endtask

  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", i, 32'(ovld[i]), 32'd0);
      chk("rst_primed", i, 32'(prim[i]), 32'd0);
      chk("rst_ram_we", i, 32'(we[i]), 32'd0);
      chk("rst_ram_re", i, 32'(re[i]), 32'd0);
      chk("rst_count", i, cnt_of(i), 32'd0);
    end
    model_clear();
    @(posedge CLK);
    @(negedge CLK);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) mem0[k] = 8'($urandom);
    mem1[0] = 8'($urandom);
    rdat[0] = 8'($urandom);
    rdat[1] = 8'($urandom);
    model_clear();
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 1'b1;
    #3;
    for (int i = 0; i < 2; i++) begin
      chk("reset_in_ready", i, 32'(rdy[i]), 32'd1);
      chk("reset_out_valid", i, 32'(ovld[i]), 32'd0);
      chk("reset_ram_we", i, 32'(we[i]), 32'd0);
      chk("reset_count", i, cnt_of(i), 32'd0);
    end
    @(negedge CLK);
    reset_n = 1'b1;

    for (int k = 1; k <= 4; k++) cyc(1'b1, 8'(k), 1'b1, 1'b0);
    for (int k = 5; k <= 10; k++) cyc(1'b1, 8'(k), 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'h20 + 8'(k), 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b1, 8'h30 + 8'(k), 1'b1, 1'b0);

    cyc(1'b1, 8'hEE, 1'b1, 1'b1);
    for (int k = 0; k < 7; k++) cyc(1'b1, 8'h40 + 8'(k), 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h50, 1'b0, 1'b0);
    chk("pre_reset_valid", 0, 32'(ovld[0]), 32'd1);
    reset_pulse();
    for (int k = 1; k <= 6; k++) cyc(1'b1, 8'(k), 1'b1, 1'b0);

    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 8'hA0, 1'b1, 1'b0);
    cyc(1'b1, 8'hA1, 1'b1, 1'b0);
    cyc(1'b1, 8'hA2, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    for (int k = 0; k < 1500; k++) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom),
          1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
